// File: rtl/pipe_flow_ctrl.sv
// Flow controller for an enable-gated delay line of STAGES cycles: tracks which
// stages hold valid words, applies backpressure, and sequences flush/clear.
module pipe_flow_ctrl #(
  parameter  int STAGES = 4,
  localparam int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             In_valid,
  output logic             In_ready,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic             Pipe_enable,
  input  logic             Flush,
  input  logic             Clear,
  output logic             Flush_done,
  output logic [OCC_W-1:0] Occupancy,
  output logic             Busy
);

  generate
    if (STAGES < 1 || STAGES > 64) begin : g_bad_stages
      $fatal(1, "pipe_flow_ctrl: STAGES must lie in 1..64");
    end
  endgenerate

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [STAGES-1:0]  r_v;
  logic [OCC_W-1:0]   r_occ;
  logic               r_flush_done;
  logic               w_flush_done_nxt;
  logic               w_pipe_en;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_xfer;

  // Reset gates the handshake outputs too, so nothing moves while it is held.
  assign w_pipe_en   = (!r_v[STAGES-1] | Out_ready) & !Clear & !Reset;
  assign w_out_valid = r_v[STAGES-1] & !Clear & !Reset;
  assign w_in_ready  = w_pipe_en & (r_state == ST_RUN) & !Flush;
  assign w_accept    = In_valid & w_in_ready;
  assign w_xfer      = w_out_valid & Out_ready;

  assign Pipe_enable = w_pipe_en;
  assign Out_valid   = w_out_valid;
  assign In_ready    = w_in_ready;
  assign Flush_done  = r_flush_done;
  assign Occupancy   = r_occ;
  assign Busy        = (r_occ != '0) | (r_state == ST_FLUSH);

  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      r_v <= '0;
    end else if (w_pipe_en) begin
      r_v[0] <= w_accept;
      for (int i = 1; i < STAGES; i++) begin
        r_v[i] <= r_v[i-1];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      r_occ <= '0;
    end else begin
      case ({w_accept, w_xfer})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // The drain completes one cycle after the registered count is seen empty.
  always_comb begin
    w_state_nxt      = r_state;
    w_flush_done_nxt = 1'b0;
    if (Clear) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (Flush) w_state_nxt = ST_FLUSH;
        end
        ST_FLUSH: begin
          if (r_occ == '0) begin
            w_state_nxt      = ST_RUN;
            w_flush_done_nxt = 1'b1;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state      <= ST_RUN;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_done <= w_flush_done_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Bench for pipe_flow_ctrl: a word-position model of the delay line checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_pipe_flow_ctrl;
  localparam int STAGES = 4;
  localparam int OCC_W  = $clog2(STAGES + 1);

  logic             Clock = 1'b0;
  logic             Reset, In_valid, In_ready, Out_valid, Out_ready;
  logic             Pipe_enable, Flush, Clear, Flush_done, Busy;
  logic [OCC_W-1:0] Occupancy;

  int n_cmp  = 0;
  int n_fail = 0;
  bit mdl_on = 1'b0;

  always #5 Clock = ~Clock;

  pipe_flow_ctrl #(.STAGES(STAGES)) dut (
    .Clock(Clock), .Reset(Reset), .In_valid(In_valid), .In_ready(In_ready),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .Pipe_enable(Pipe_enable),
    .Flush(Flush), .Clear(Clear), .Flush_done(Flush_done),
    .Occupancy(Occupancy), .Busy(Busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each in-flight word is held as the number of stages it has advanced.
  int pos_q[$];
  bit m_flush = 1'b0;
  bit m_done  = 1'b0;

  always @(negedge Clock) begin : mdl
    bit head_end, en, ov, ir;
    logic [STAGES-1:0] ev;
    if (mdl_on) begin
      head_end = (pos_q.size() > 0) && (pos_q[0] == STAGES - 1);
      en = !Reset && !Clear && (!head_end || Out_ready);
      ov = !Reset && !Clear && head_end;
      ir = en && !m_flush && !Flush;
      ev = '0;
      foreach (pos_q[k]) ev[pos_q[k]] = 1'b1;
      chk("in_ready", In_ready, ir);
      chk("out_valid", Out_valid, ov);
      chk("pipe_enable", Pipe_enable, en);
      chk("occupancy", Occupancy, pos_q.size());
      chk("busy", Busy, (pos_q.size() != 0) || m_flush);
      chk("flush_done", Flush_done, m_done);
      chk("valid_shadow", dut.r_v, ev);
      if (Reset || Clear) begin
        pos_q.delete();
        m_flush = 1'b0;
        m_done  = 1'b0;
      end else begin
        m_done = m_flush && (pos_q.size() == 0);
        if (m_flush) m_flush = (pos_q.size() != 0);
        else         m_flush = Flush;
        if (en) begin
          if (head_end) void'(pos_q.pop_front());
          foreach (pos_q[k]) pos_q[k] = pos_q[k] + 1;
          if (ir && In_valid) pos_q.push_back(0);
        end
      end
    end
  end

  task automatic drive(input bit rst, input bit iv, input bit ordy, input bit fl, input bit cl);
    @(posedge Clock);
    #1;
    Reset = rst; In_valid = iv; Out_ready = ordy; Flush = fl; Clear = cl;
    @(negedge Clock);
  endtask

  initial begin
    int first_acc, first_out, xfers, dones;
    bit done_seen;
    Reset = 1'b1; In_valid = 1'b0; Out_ready = 1'b0; Flush = 1'b0; Clear = 1'b0;
    @(posedge Clock);
    #1;
    mdl_on = 1'b1;
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    chk("rst_in_ready", In_ready, 1);
    chk("rst_out_valid", Out_valid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_occ", Occupancy, 0);

    // Continuous streaming
    first_acc = -1; first_out = -1; xfers = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, i < 10, 1, 0, 0);
      if (In_valid && In_ready && first_acc < 0) first_acc = i;
      if (Out_valid && first_out < 0) first_out = i;
      if (Out_valid && Out_ready) xfers++;
      if (i >= 4 && i <= 9) chk("stream_occ", Occupancy, 4);
      if (i >= 4 && i <= 13) chk("stream_out_valid", Out_valid, 1);
    end
    chk("stream_first_acc", first_acc, 0);
    chk("stream_latency", first_out - first_acc, 4);
    chk("stream_xfers", xfers, 10);

    // Backpressure
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, 0);
    chk("bp_full_occ", Occupancy, 4);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 0);
      chk("bp_pipe_enable", Pipe_enable, 0);
      chk("bp_in_ready", In_ready, 0);
      chk("bp_out_valid", Out_valid, 1);
      chk("bp_occ", Occupancy, 4);
    end
    xfers = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 0, 0);
      if (Out_valid && Out_ready) xfers++;
    end
    chk("bp_release_xfers", xfers, 4);
    chk("bp_release_occ", Occupancy, 0);

    // Flush with three words in flight
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 1, 0);
    chk("flush_req_in_ready", In_ready, 0);
    xfers = (Out_valid && Out_ready) ? 1 : 0;
    dones = 0; done_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 1, 0, 0);
      if (Out_valid && Out_ready) xfers++;
      if (Flush_done) begin
        dones++;
        done_seen = 1'b1;
      end else if (!done_seen) begin
        chk("flush_in_ready", In_ready, 0);
      end
    end
    chk("flush_xfers", xfers, 3);
    chk("flush_done_count", dones, 1);
    chk("flush_back_to_run", In_ready, 1);
    chk("flush_idle", Busy, 0);

    // Flush while empty
    drive(0, 0, 1, 1, 0);
    drive(0, 0, 1, 0, 0);
    chk("eflush_done_t1", Flush_done, 0);
    chk("eflush_busy_t1", Busy, 1);
    drive(0, 0, 1, 0, 0);
    chk("eflush_done_t2", Flush_done, 1);
    chk("eflush_in_ready_t2", In_ready, 1);
    drive(0, 0, 1, 0, 0);
    chk("eflush_done_t3", Flush_done, 0);

    // Clear together with Flush while full
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, 0);
    chk("clr_full_occ", Occupancy, 4);
    drive(0, 0, 0, 1, 1);
    chk("clr_in_ready", In_ready, 0);
    chk("clr_out_valid", Out_valid, 0);
    chk("clr_pipe_enable", Pipe_enable, 0);
    drive(0, 0, 0, 0, 0);
    chk("clr_occ", Occupancy, 0);
    chk("clr_out_valid_after", Out_valid, 0);
    chk("clr_run", In_ready, 1);
    chk("clr_busy", Busy, 0);
    for (int i = 0; i < 3; i++) begin
      chk("clr_no_done", Flush_done, 0);
      drive(0, 0, 0, 0, 0);
    end

    // Reset mid-flush with two words held
    for (int i = 0; i < 2; i++) drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    chk("rflush_busy", Busy, 1);
    chk("rflush_occ", Occupancy, 2);
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1, 0, 0);
      chk("rflush_rst_in_ready", In_ready, 0);
      chk("rflush_rst_out_valid", Out_valid, 0);
      chk("rflush_rst_pipe_enable", Pipe_enable, 0);
    end
    drive(0, 0, 0, 0, 0);
    chk("rflush_out_valid", Out_valid, 0);
    chk("rflush_in_ready", In_ready, 1);
    chk("rflush_busy_after", Busy, 0);
    chk("rflush_occ_after", Occupancy, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0);
      chk("rflush_no_done", Flush_done, 0);
    end

    // Random traffic with occasional flush, clear and reset
    for (int i = 0; i < 10000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      drive(r < 2, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
            (r >= 7) && (r < 27), (r >= 2) && (r < 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_flow_ctrl.md
PIPE_FLOW_CTRL -- requirements
Module: pipe_flow_ctrl

Interface
REQ-001 The block SHALL have parameter STAGES, default 4, meaning the latency in clock cycles of the enable-gated delay line being controlled; legal range 1..64.
REQ-002 The block SHALL have localparam OCC_W = clog2(STAGES+1), meaning the occupancy counter width.
REQ-003 The block SHALL have port Clock  in  1  system clock; all logic on the rising edge.
REQ-004 The block SHALL have port Reset  in  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port In_valid  in  1  upstream word valid.
REQ-006 The block SHALL have port In_ready  out  1  upstream word accepted when In_valid and In_ready are both 1.
REQ-007 The block SHALL have port Out_valid  out  1  delay-line output word valid.
REQ-008 The block SHALL have port Out_ready  in  1  downstream accepts the word.
REQ-009 The block SHALL have port Pipe_enable  out  1  drives the Enable input of the controlled delay line.
REQ-010 The block SHALL have port Flush  in  1  single-cycle request to drain the pipeline.
REQ-011 The block SHALL have port Clear  in  1  single-cycle request to discard all in-flight words.
REQ-012 The block SHALL have port Flush_done  out  1  one-cycle pulse when a drain completes.
REQ-013 The block SHALL have port Occupancy  out  OCC_W  count of valid words in the delay line.
REQ-014 The block SHALL have port Busy  out  1  high when Occupancy != 0 or the state is FLUSH.
REQ-015 A STAGES value outside 1..64 SHALL fail elaboration via ASSERT.

Function
REQ-016 The block SHALL keep a STAGES-bit valid shadow v[0..STAGES-1] that mirrors the delay-line stages.
REQ-017 Pipe_enable SHALL be combinational: (!v[STAGES-1] | Out_ready) & !Clear.
REQ-018 Out_valid SHALL equal v[STAGES-1] & !Clear.
REQ-019 In_ready SHALL equal Pipe_enable & (state == RUN) & !Flush.
REQ-020 When Pipe_enable is 1, the valid shadow SHALL update as v[0] <= In_valid & In_ready and v[i] <= v[i-1]; when Pipe_enable is 0, v SHALL hold.
REQ-021 A word accepted in cycle t SHALL present Out_valid no earlier than cycle t+STAGES, exactly t+STAGES when there is no stall.
REQ-022 Out_valid SHALL NOT fall while Out_ready is 0 (the output is stable under backpressure).
REQ-023 Occupancy SHALL be a registered counter: +1 on input accept, -1 on output transfer, unchanged when both or neither occur.
REQ-024 Occupancy SHALL always equal popcount(v) and SHALL never exceed STAGES.
REQ-025 The state machine SHALL have two states, RUN and FLUSH.
REQ-026 RUN SHALL transition to FLUSH on Flush=1, and In_ready SHALL already be 0 in that cycle.
REQ-027 In FLUSH, In_ready SHALL be 0, the delay line SHALL advance per REQ-017, and the block SHALL return to RUN with Flush_done=1 in the cycle after registered Occupancy == 0 is observed.
REQ-028 Flush while Occupancy == 0 SHALL produce Flush_done in the second cycle after the request.
REQ-029 Flush while already in FLUSH SHALL be ignored.
REQ-030 Flush_done SHALL be registered and high for exactly one cycle per completed drain.
REQ-031 Clear SHALL zero v and Occupancy and force the state to RUN on the next edge.
REQ-032 During the Clear cycle, In_ready, Out_valid and Pipe_enable SHALL all be 0.
REQ-033 Clear SHALL override a simultaneous Flush, and a Clear during FLUSH SHALL abort the drain without producing Flush_done.

Reset
REQ-034 Reset SHALL have priority over Clear and Flush.
REQ-035 On Reset, v SHALL be 0, Occupancy SHALL be 0, state SHALL be RUN and Flush_done SHALL be 0.
REQ-036 While Reset is asserted, In_ready, Out_valid and Pipe_enable SHALL be 0.
REQ-037 After Reset deasserts, Out_valid SHALL be 0, In_ready SHALL be 1 and Busy SHALL be 0.
REQ-038 Reset asserted mid-FLUSH SHALL discard the drain and produce no Flush_done.

Verification (STAGES=4)
REQ-039 The bench SHALL cover continuous streaming: In_valid=1 for 10 cycles with Out_ready=1 -> first Out_valid 4 cycles after the first accept, 10 consecutive transfers, Occupancy steady at 4.
REQ-040 The bench SHALL cover backpressure: pipe full, Out_ready=0 for 5 cycles -> Pipe_enable=0, In_ready=0, Out_valid held at 1, Occupancy held at 4; on release -> transfers resume with no loss or duplication (scoreboard check).
REQ-041 The bench SHALL cover flush: 3 words in flight, then Flush -> In_ready=0 from the request cycle, 3 outputs, then exactly one Flush_done pulse and return to RUN.
REQ-042 The bench SHALL cover Clear while full together with Flush in the same cycle -> next cycle Occupancy=0, Out_valid=0, state RUN, no Flush_done.
REQ-043 The bench SHALL cover Reset asserted mid-FLUSH with Occupancy=2 -> all outputs at reset values and no Flush_done afterwards.
REQ-044 The bench SHALL cover random In_valid and Out_ready over 10k cycles -> Occupancy == popcount(v) every cycle, and an in-order scoreboard against a reference delay line matches.
